// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-period symbols and the mod-5 phase geometry
// used by the 10:2 serializer.
package tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    localparam int PHASE_W = 3;
    localparam logic [PHASE_W-1:0] PHASE_LAST = 3'd4;

endpackage

// File: rtl/mod5_phase.sv
// Free-running 0..4 phase counter with a registered strobe marking the last
// phase, so the load edge is known one cycle ahead without decode glitches.
module mod5_phase
    import tmds_pkg::*;
(
    input  logic               clki,
    input  logic               rstn,
    output logic [PHASE_W-1:0] phase_o,
    output logic               load_o
);

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            phase_o <= '0;
            load_o  <= 1'b0;
        end else begin
            if (phase_o == PHASE_LAST)
                phase_o <= '0;
            else
                phase_o <= phase_o + 3'd1;
            load_o <= (phase_o == (PHASE_LAST - 3'd1));
        end
    end

endmodule

// File: rtl/tmds_gearbox_10to2.sv
// One-lane TMDS serializer in the 5x clock domain: accepts a 10-bit symbol per
// five cycles through a one-deep hold register and emits two bits per cycle.
module tmds_gearbox_10to2
    import tmds_pkg::*;
#(
    parameter logic [9:0] IDLE_WORD = TMDS_CTRL_00,
    parameter bit         LSB_FIRST = 1'b1
) (
    input  logic               clki,
    input  logic               rstn,
    input  logic [9:0]         word_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [1:0]         bits_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               load_o,
    output logic               underflow_o,
    input  logic               uf_clr_i
);

    logic [9:0] cur_word;
    logic [9:0] hold_word;
    logic       hold_full;
    logic       transfer;

    mod5_phase u_phase (
        .clki    (clki),
        .rstn    (rstn),
        .phase_o (phase_o),
        .load_o  (load_o)
    );

    // On the load edge the hold slot drains into cur, so it can take a new word.
    assign ready_o  = !hold_full || load_o;
    assign transfer = valid_i && ready_o;

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            cur_word    <= IDLE_WORD;
            hold_word   <= '0;
            hold_full   <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (load_o) begin
                if (hold_full) begin
                    cur_word  <= hold_word;
                    hold_full <= transfer;
                    if (transfer)
                        hold_word <= word_i;
                end else if (transfer) begin
                    cur_word  <= word_i;
                    hold_full <= 1'b0;
                end else begin
                    cur_word    <= IDLE_WORD;
                    underflow_o <= 1'b1;
                end
            end else if (transfer) begin
                hold_word <= word_i;
                hold_full <= 1'b1;
            end

            // A clear never masks an underflow inserted on the same edge.
            if (uf_clr_i && !(load_o && !hold_full && !transfer))
                underflow_o <= 1'b0;
        end
    end

    always_comb begin
        bits_o = 2'b00;
        case (phase_o)
            3'd0: bits_o = LSB_FIRST ? cur_word[1:0] : cur_word[9:8];
            3'd1: bits_o = LSB_FIRST ? cur_word[3:2] : cur_word[7:6];
            3'd2: bits_o = LSB_FIRST ? cur_word[5:4] : cur_word[5:4];
            3'd3: bits_o = LSB_FIRST ? cur_word[7:6] : cur_word[3:2];
            3'd4: bits_o = LSB_FIRST ? cur_word[9:8] : cur_word[1:0];
            default: bits_o = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_tmds_gearbox_10to2.sv
// Directed bench for the TMDS 10:2 gearbox: idle/underflow pattern, streaming
// table, bypass load, hold-register ordering and mid-symbol reset.
module tb_tmds_gearbox_10to2;

    logic       clki;
    logic       rstn;
    logic [9:0] word_i;
    logic       valid_i;
    logic       ready_o;
    logic [1:0] bits_o;
    logic [2:0] phase_o;
    logic       load_o;
    logic       underflow_o;
    logic       uf_clr_i;

    int total;
    int bad;

    typedef struct {
        logic       valid;
        logic [9:0] word;
        logic       clr;
        logic [1:0] bits;
        logic       ready;
        logic [2:0] phase;
        logic       uf;
    } vec_t;

    vec_t       tbl [22];
    logic [1:0] idle_pair [5];
    logic [1:0] w1f0_pair [5];
    logic [1:0] w0f3_pair [5];
    logic [1:0] w3c5_pair [5];

    tmds_gearbox_10to2 dut (
        .clki        (clki),
        .rstn        (rstn),
        .word_i      (word_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .bits_o      (bits_o),
        .phase_o     (phase_o),
        .load_o      (load_o),
        .underflow_o (underflow_o),
        .uf_clr_i    (uf_clr_i)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    task automatic applyStimulus(input logic v, input logic [9:0] w, input logic c);
        valid_i  = v;
        word_i   = w;
        uf_clr_i = c;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clki);
        #1;
    endtask

    task automatic runToPhase(input logic [2:0] p);
        int n = 0;
        while (phase_o !== p && n < 10) begin
            step();
            n++;
        end
        checkOutput("sync_phase", 32'(phase_o), 32'(p));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        idle_pair = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
        w1f0_pair = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b01};
        w0f3_pair = '{2'b11, 2'b00, 2'b11, 2'b11, 2'b00};
        w3c5_pair = '{2'b01, 2'b01, 2'b00, 2'b11, 2'b11};

        //            valid  word    clr   bits   ready phase uf
        tbl[0]  = '{1'b1, 10'h3FF, 1'b0, 2'b11, 1'b1, 3'd4, 1'b0};
        tbl[1]  = '{1'b1, 10'h000, 1'b0, 2'b11, 1'b1, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 10'h2AA, 1'b0, 2'b11, 1'b0, 3'd1, 1'b0};
        tbl[3]  = '{1'b1, 10'h2AA, 1'b0, 2'b11, 1'b0, 3'd2, 1'b0};
        tbl[4]  = '{1'b1, 10'h2AA, 1'b0, 2'b11, 1'b0, 3'd3, 1'b0};
        tbl[5]  = '{1'b1, 10'h2AA, 1'b0, 2'b11, 1'b1, 3'd4, 1'b0};
        tbl[6]  = '{1'b1, 10'h155, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
        tbl[7]  = '{1'b1, 10'h155, 1'b0, 2'b00, 1'b0, 3'd1, 1'b0};
        tbl[8]  = '{1'b1, 10'h155, 1'b0, 2'b00, 1'b0, 3'd2, 1'b0};
        tbl[9]  = '{1'b1, 10'h155, 1'b0, 2'b00, 1'b0, 3'd3, 1'b0};
        tbl[10] = '{1'b1, 10'h155, 1'b0, 2'b00, 1'b1, 3'd4, 1'b0};
        tbl[11] = '{1'b0, 10'h000, 1'b0, 2'b10, 1'b0, 3'd0, 1'b0};
        tbl[12] = '{1'b0, 10'h000, 1'b0, 2'b10, 1'b0, 3'd1, 1'b0};
        tbl[13] = '{1'b0, 10'h000, 1'b0, 2'b10, 1'b0, 3'd2, 1'b0};
        tbl[14] = '{1'b0, 10'h000, 1'b0, 2'b10, 1'b0, 3'd3, 1'b0};
        tbl[15] = '{1'b0, 10'h000, 1'b0, 2'b10, 1'b1, 3'd4, 1'b0};
        tbl[16] = '{1'b0, 10'h000, 1'b0, 2'b01, 1'b1, 3'd0, 1'b0};
        tbl[17] = '{1'b0, 10'h000, 1'b0, 2'b01, 1'b1, 3'd1, 1'b0};
        tbl[18] = '{1'b0, 10'h000, 1'b0, 2'b01, 1'b1, 3'd2, 1'b0};
        tbl[19] = '{1'b0, 10'h000, 1'b0, 2'b01, 1'b1, 3'd3, 1'b0};
        tbl[20] = '{1'b0, 10'h000, 1'b1, 2'b01, 1'b1, 3'd4, 1'b0};
        tbl[21] = '{1'b0, 10'h000, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1};

        rstn = 1'b0;
        applyStimulus(1'b0, 10'h000, 1'b0);
        repeat (3) @(posedge clki);
        #3 rstn = 1'b1;

        checkOutput("rst_phase", 32'(phase_o), 32'd0);
        checkOutput("rst_bits", 32'(bits_o), 32'(idle_pair[0]));
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_load", 32'(load_o), 32'd0);
        checkOutput("rst_uf", 32'(underflow_o), 32'd0);

        // Idle stream: IDLE_WORD repeats, underflow sets after the first load edge.
        for (int k = 0; k < 20; k++) begin
            checkOutput("idle_phase", 32'(phase_o), 32'(k % 5));
            checkOutput("idle_bits", 32'(bits_o), 32'(idle_pair[k % 5]));
            checkOutput("idle_load", 32'(load_o), 32'((k % 5) == 4));
            checkOutput("idle_uf", 32'(underflow_o), 32'(k >= 5));
            step();
        end

        applyStimulus(1'b0, 10'h000, 1'b1);
        checkOutput("clr_before", 32'(underflow_o), 32'd1);
        step();
        applyStimulus(1'b0, 10'h000, 1'b0);
        checkOutput("clr_after", 32'(underflow_o), 32'd0);
        runToPhase(3'd4);

        // Back-to-back stream; last entry clears on the underflow load edge.
        for (int i = 0; i < 22; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].word, tbl[i].clr);
            checkOutput("tbl_bits", 32'(bits_o), 32'(tbl[i].bits));
            checkOutput("tbl_ready", 32'(ready_o), 32'(tbl[i].ready));
            checkOutput("tbl_phase", 32'(phase_o), 32'(tbl[i].phase));
            checkOutput("tbl_load", 32'(load_o), 32'(tbl[i].phase == 3'd4));
            checkOutput("tbl_uf", 32'(underflow_o), 32'(tbl[i].uf));
            step();
        end
        applyStimulus(1'b0, 10'h000, 1'b0);

        // Bypass: word offered in phase 4 with empty hold appears next cycle.
        runToPhase(3'd4);
        applyStimulus(1'b1, 10'h1F0, 1'b0);
        checkOutput("byp_ready", 32'(ready_o), 32'd1);
        step();
        applyStimulus(1'b0, 10'h000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("byp_bits", 32'(bits_o), 32'(w1f0_pair[k]));
            step();
        end

        // Early word goes to hold, second word in phase 4 queues behind it.
        runToPhase(3'd1);
        applyStimulus(1'b1, 10'h0F3, 1'b0);
        checkOutput("hold_rdy_p1", 32'(ready_o), 32'd1);
        step();
        applyStimulus(1'b0, 10'h000, 1'b0);
        checkOutput("hold_rdy_p2", 32'(ready_o), 32'd0);
        step();
        checkOutput("hold_rdy_p3", 32'(ready_o), 32'd0);
        step();
        applyStimulus(1'b1, 10'h3C5, 1'b0);
        checkOutput("hold_rdy_p4", 32'(ready_o), 32'd1);
        step();
        applyStimulus(1'b0, 10'h000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("hold_w1_bits", 32'(bits_o), 32'(w0f3_pair[k]));
            step();
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput("hold_w2_bits", 32'(bits_o), 32'(w3c5_pair[k]));
            step();
        end
        checkOutput("hold_idle_after", 32'(bits_o), 32'(idle_pair[0]));

        // Asynchronous reset in phase 2 with a word waiting in hold.
        runToPhase(3'd1);
        applyStimulus(1'b1, 10'h3A5, 1'b0);
        step();
        applyStimulus(1'b0, 10'h000, 1'b0);
        checkOutput("mid_ready_full", 32'(ready_o), 32'd0);
        #2 rstn = 1'b0;
        #1;
        checkOutput("mid_rst_bits", 32'(bits_o), 32'(idle_pair[0]));
        checkOutput("mid_rst_phase", 32'(phase_o), 32'd0);
        checkOutput("mid_rst_ready", 32'(ready_o), 32'd1);
        checkOutput("mid_rst_load", 32'(load_o), 32'd0);
        checkOutput("mid_rst_uf", 32'(underflow_o), 32'd0);
        #2 rstn = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            checkOutput("post_rst_bits", 32'(bits_o), 32'(idle_pair[k % 5]));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
